// File: rtl/mux_nx1_rr_if.sv
// mux_nx1_rr_if: bundle of the per-channel input handshakes, the force-select
// controls and the output handshake of the round-robin multiplexer.
//
// Handshake rule (inputs and output alike): a word moves across a channel on a
// rising clk edge where that channel's valid and ready are both 1. A producer
// holds valid and data stable until the transfer. Ready may depend on valid
// in the same cycle. Valid must never wait for ready.
//
// Signals
//   inp       N_CH*WIDTH  channel i data at inp[i*WIDTH +: WIDTH]
//   inp_valid N_CH        channel i offers data
//   inp_ready N_CH        channel i is accepted this cycle (one-hot or zero)
//   force_en  1           restrict arbitration to channel sel_in
//   sel_in    SEL_W       forced channel index
//   op        WIDTH       registered output data
//   op_valid  1           op holds valid data
//   op_ready  1           consumer accepts op
//   op_ch     SEL_W       channel index that produced op
// Modports: master = producers/consumer side, slave = the multiplexer.
interface mux_nx1_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
);
  logic [N_CH*WIDTH-1:0] inp;
  logic [N_CH-1:0]       inp_valid;
  logic [N_CH-1:0]       inp_ready;
  logic                  force_en;
  logic [SEL_W-1:0]      sel_in;
  logic [WIDTH-1:0]      op;
  logic                  op_valid;
  logic                  op_ready;
  logic [SEL_W-1:0]      op_ch;

  modport master (
    output inp, inp_valid, force_en, sel_in, op_ready,
    input  inp_ready, op, op_valid, op_ch
  );

  modport slave (
    input  inp, inp_valid, force_en, sel_in, op_ready,
    output inp_ready, op, op_valid, op_ch
  );
endinterface

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N_CH-channel, WIDTH-bit registered multiplexer. A round-robin
// arbiter picks one valid input channel per cycle (or only channel sel_in
// when force_en=1) and loads it into a single output register with
// backpressure.
//
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mux_nx1_rr_if (input/output handshakes, force select)
//
// The output slot is a two-state machine (EMPTY/FULL); its state is exposed
// directly as bus.op_valid.
module mux_nx1_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nx1_rr_if.slave    bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [SEL_W-1:0] op_ch_q, op_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]  elig;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             xfer;

  // Eligible set. An out-of-range forced index selects nothing.
  always_comb begin
    elig = '0;
    if (bus.force_en) begin
      if (int'(bus.sel_in) < N_CH) elig[bus.sel_in] = bus.inp_valid[bus.sel_in];
    end else begin
      elig = bus.inp_valid;
    end
  end

  // First eligible channel scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

  assign load_en = (state_q == EMPTY) || bus.op_ready;
  // rst_n gating keeps inp_ready low while reset is held (slot reads EMPTY then).
  assign xfer    = load_en && gnt_any && rst_n;

  always_comb begin
    bus.inp_ready = '0;
    if (xfer) bus.inp_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    op_ch_d  = op_ch_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        state_d  = FULL;
        op_d     = bus.inp[int'(gnt_idx)*WIDTH +: WIDTH];
        op_ch_d  = gnt_idx;
        rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        // Slot drains; op/op_ch keep their stale values.
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      op_q     <= '0;
      op_ch_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      op_ch_q  <= op_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.op       = op_q;
  assign bus.op_ch    = op_ch_q;
  assign bus.op_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux_nx1_rr.sv
module tb_mux_nx1_rr;
  logic clk;
  logic rst_n;

  mux_nx1_rr_if #(.N_CH(4), .WIDTH(8)) bus4 ();
  mux_nx1_rr_if #(.N_CH(3), .WIDTH(8)) bus3 ();

  mux_nx1_rr #(.N_CH(4), .WIDTH(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  mux_nx1_rr #(.N_CH(3), .WIDTH(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change and outputs are
  // sampled here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [3:0] v, input logic rdy, input logic fe, input logic [1:0] sel);
    bus4.inp_valid = v;
    bus4.op_ready  = rdy;
    bus4.force_en  = fe;
    bus4.sel_in    = sel;
    #1;
  endtask

  task automatic drive3(input logic [2:0] v, input logic rdy, input logic fe, input logic [1:0] sel);
    bus3.inp_valid = v;
    bus3.op_ready  = rdy;
    bus3.force_en  = fe;
    bus3.sel_in    = sel;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] e;
    bus4.inp = {8'h13, 8'h12, 8'h11, 8'h10};
    bus3.inp = {8'h22, 8'h21, 8'h20};
    drive4(4'b1111, 1'b1, 1'b0, 2'd0);
    drive3(3'b000, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #3;
    check("rst_op_valid", bus4.op_valid, 0);
    check("rst_op", bus4.op, 0);
    check("rst_op_ch", bus4.op_ch, 0);
    check("rst_inp_ready", bus4.inp_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Round robin, all valid, consumer always ready: 0,1,2,3,0,1 with no bubbles.
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rr_inp_ready", bus4.inp_ready, 32'd1 << e);
      step();
      check("rr_op_valid", bus4.op_valid, 1);
      check("rr_op_ch", bus4.op_ch, e);
      check("rr_op", bus4.op, 8'h10 + e);
    end

    // Backpressure: slot FULL with ch1, consumer stalls 3 cycles.
    drive4(4'b1111, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_inp_ready", bus4.inp_ready, 0);
      step();
      check("bp_op_ch", bus4.op_ch, 1);
      check("bp_op", bus4.op, 8'h11);
      check("bp_op_valid", bus4.op_valid, 1);
    end
    drive4(4'b1111, 1'b1, 1'b0, 2'd0);
    check("bp_release_ready", bus4.inp_ready, 4'b0100);
    step();
    check("bp_release_ch", bus4.op_ch, 2);

    // Wrap-around: grant ch3, then only ch0/ch3 valid -> ch0, then ch3.
    check("wrap_g3_ready", bus4.inp_ready, 4'b1000);
    step();
    check("wrap_g3_ch", bus4.op_ch, 3);
    drive4(4'b1001, 1'b1, 1'b0, 2'd0);
    check("wrap_g0_ready", bus4.inp_ready, 4'b0001);
    step();
    check("wrap_g0_ch", bus4.op_ch, 0);
    check("wrap_g3b_ready", bus4.inp_ready, 4'b1000);
    step();
    check("wrap_g3b_ch", bus4.op_ch, 3);

    // Single channel ch2 with data A5.
    bus4.inp = {8'h13, 8'hA5, 8'h11, 8'h10};
    drive4(4'b0100, 1'b1, 1'b0, 2'd0);
    check("single_ready", bus4.inp_ready, 4'b0100);
    step();
    check("single_op", bus4.op, 8'hA5);
    check("single_op_ch", bus4.op_ch, 2);
    check("single_op_valid", bus4.op_valid, 1);
    bus4.inp = {8'h13, 8'h12, 8'h11, 8'h10};

    // Force mode: only ch3, every cycle.
    drive4(4'b1111, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      check("force3_ready", bus4.inp_ready, 4'b1000);
      step();
      check("force3_op_ch", bus4.op_ch, 3);
    end
    drive4(4'b1111, 1'b1, 1'b1, 2'd1);
    check("force1_ready", bus4.inp_ready, 4'b0010);
    step();
    check("force1_op", bus4.op, 8'h11);
    // Forced channel not valid -> nothing granted, slot drains.
    drive4(4'b0111, 1'b1, 1'b1, 2'd3);
    check("force_inv_ready", bus4.inp_ready, 0);
    step();
    check("force_inv_op_valid", bus4.op_valid, 0);
    drive4(4'b0000, 1'b1, 1'b0, 2'd0);

    // Three-channel instance: wrap at ch2, then an out-of-range forced index.
    drive3(3'b111, 1'b1, 1'b0, 2'd0);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("n3_inp_ready", bus3.inp_ready, 32'd1 << e);
      step();
      check("n3_op_ch", bus3.op_ch, e);
      check("n3_op", bus3.op, 8'h20 + e);
    end
    drive3(3'b111, 1'b1, 1'b1, 2'd3);
    check("n3_oor_ready", bus3.inp_ready, 0);
    step();
    check("n3_oor_op_valid", bus3.op_valid, 0);

    // Asynchronous reset mid-stream while op_valid=1.
    drive4(4'b0010, 1'b1, 1'b0, 2'd0);
    step();
    check("pre_arst_valid", bus4.op_valid, 1);
    drive4(4'b1111, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check("arst_op_valid", bus4.op_valid, 0);
    check("arst_op", bus4.op, 0);
    check("arst_op_ch", bus4.op_ch, 0);
    check("arst_inp_ready", bus4.inp_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_arst_ready", bus4.inp_ready, 4'b0001);
    step();
    check("post_arst_op_ch", bus4.op_ch, 0);
    check("post_arst_op_valid", bus4.op_valid, 1);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
